fifo_sync: RTL
==============

FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, meaning entry count; power of two, >=4.
REQ-003 SHALL have parameter FWFT, default 0, meaning read mode: 0 = standard registered read, 1 = first-word-fall-through (show-ahead).
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-2, meaning almost_full threshold (1..DEPTH-1).
REQ-005 SHALL have parameter AE_LEVEL, default 2, meaning almost_empty threshold (1..DEPTH-1).
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  one clock; reset is synchronous and active-high.
REQ-008 wr_en  input  1  write request.
REQ-009 data_in  input  DATA_WIDTH  write data.
REQ-010 rd_en  input  1  read request (FWFT=1: acknowledge/pop of the presented word).
REQ-011 err_clr  input  1  clears sticky error flags.
REQ-012 data_out  output  DATA_WIDTH  read data.
REQ-013 full / empty  output  1 each  occupancy == DEPTH / == 0.
REQ-014 almost_full / almost_empty  output  1 each  count >= AF_LEVEL / count <= AE_LEVEL.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 overflow / underflow  output  1 each  sticky rejected-write / rejected-read flags.

Function
REQ-017 Read accepted (rd_acc) SHALL be rd_en && !empty.
REQ-018 Write accepted (wr_acc) SHALL be wr_en && (!full || rd_acc); when full, simultaneous read+write both complete and count is unchanged.
REQ-019 When empty, wr_en+rd_en SHALL accept the write only, reject the read, and set underflow.
REQ-020 Pointers SHALL be $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0 on accept, with no gap or duplicate entry at wrap.
REQ-021 count SHALL update at the accepting edge: +1 (wr_acc only), -1 (rd_acc only), unchanged (both or neither).
REQ-022 full, empty, almost_full, almost_empty SHALL be decoded from the registered count only and be valid in the cycle after the accepting edge.
REQ-023 FWFT=0: on rd_acc, data_out SHALL load mem[rd_ptr] at that edge (1-cycle latency) and hold its value otherwise.
REQ-024 FWFT=1: data_out SHALL equal mem[rd_ptr] whenever !empty; a word written to an empty FIFO at edge N SHALL appear at data_out in cycle N+1, together with empty deasserting; data_out is don't-care when empty.
REQ-025 overflow SHALL set at any edge with wr_en && !wr_acc; underflow at any edge with rd_en && !rd_acc; both hold until err_clr or rst.
REQ-026 err_clr SHALL clear both flags at the next edge; a new error on that same edge SHALL take priority and leave the flag set.
REQ-027 Rejected accesses SHALL modify no memory, pointer or count.

Reset
REQ-028 At an rst edge: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, and FWFT=0 data_out=0.
REQ-029 rst SHALL take priority over wr_en/rd_en/err_clr in the same cycle; asserted mid-operation, it discards all content; memory contents need not be cleared.

Structure
REQ-030 Shared package fifo_pkg SHALL hold mode constants FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1, plus the pointer/count width helper.
REQ-031 Storage SHALL be a sub-module fifo_mem_dp (sync write, async read, DATA_WIDTH x DEPTH); pointer, count, flag and error logic live in fifo_sync.
REQ-032 Parameter illegal values (non-power-of-two DEPTH, thresholds out of range) SHALL trigger an elaboration-time error.

Verification (DEPTH=16, DATA_WIDTH=8, defaults unless stated)
REQ-033 Fill/drain: 16 writes 0x00..0x0F then 16 reads -> full=1, count=16 after 16th write; reads return 0x00..0x0F in order; empty=1, count=0 at end.
REQ-034 Overflow: 17th write while full, no read -> write dropped, overflow=1, count=16; err_clr -> overflow=0 next cycle.
REQ-035 Simultaneous at boundaries: full + wr+rd of 0xAA -> count stays 16, oldest word out; empty + wr+rd -> count=1, underflow=1.
REQ-036 Wrap: 40 interleaved write/read pairs of incrementing data -> in-order data, count never exceeds 1, no loss across 2 pointer wraps.
REQ-037 FWFT=1: write 0x5C into empty FIFO at edge N -> data_out=0x5C and empty=0 in cycle N+1 without rd_en; rd_en pops it, empty=1.
REQ-038 Thresholds and reset: count 14 -> almost_full=1; count 2 -> almost_empty=1; rst at count 9 -> all REQ-028 values next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the synchronous FIFO.
// Mode values select standard registered read or first-word-fall-through.
package fifo_pkg;

   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   function automatic int fifo_ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   // One extra bit so that count can represent a completely full FIFO.
   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit fifo_is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Dual-port storage array for fifo_sync.
// Writes are synchronous; reads are combinational from the read address.
module fifo_mem_dp
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                          clk,
   input  logic                          i_we,
   input  logic [fifo_ptr_w(DEPTH)-1:0]  i_waddr,
   input  logic [DATA_WIDTH-1:0]         i_wdata,
   input  logic [fifo_ptr_w(DEPTH)-1:0]  i_raddr,
   output logic [DATA_WIDTH-1:0]         o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with count-decoded status flags and sticky error flags.
// FWFT selects a registered read port or a show-ahead read port.
module fifo_sync
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int FWFT       = 0,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [DATA_WIDTH-1:0]         data_in,
   input  logic                          rd_en,
   input  logic                          err_clr,
   output logic [DATA_WIDTH-1:0]         data_out,
   output logic                          full,
   output logic                          empty,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic [fifo_cnt_w(DEPTH)-1:0]  count,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int PW = fifo_ptr_w(DEPTH);
   localparam int CW = fifo_cnt_w(DEPTH);

   generate
      if (!fifo_is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
         $error("fifo_sync: DEPTH must be a power of two and at least 4");
      end
      if (DATA_WIDTH < 1) begin : g_bad_width
         $error("fifo_sync: DATA_WIDTH must be at least 1");
      end
      if (AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1) begin : g_bad_af
         $error("fifo_sync: AF_LEVEL must lie in 1..DEPTH-1");
      end
      if (AE_LEVEL < 1 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
         $error("fifo_sync: AE_LEVEL must lie in 1..DEPTH-1");
      end
      if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
         $error("fifo_sync: FWFT must be 0 or 1");
      end
   endgenerate

   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  r_ovf;
   logic                  r_udf;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_rd_acc;
   logic                  w_wr_acc;
   logic [DATA_WIDTH-1:0] w_rdata;

   assign w_full   = (r_count == CW'(DEPTH));
   assign w_empty  = (r_count == '0);
   assign w_rd_acc = rd_en && !w_empty;
   // A read on the same edge frees the slot, so a full FIFO still takes the write.
   assign w_wr_acc = wr_en && (!w_full || w_rd_acc);

   fifo_mem_dp #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_wr_acc),
      .i_waddr (r_wr_ptr),
      .i_wdata (data_in),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         // A fresh error outranks a clear on the same edge.
         if (wr_en && !w_wr_acc) r_ovf <= 1'b1;
         else if (err_clr)       r_ovf <= 1'b0;
         if (rd_en && !w_rd_acc) r_udf <= 1'b1;
         else if (err_clr)       r_udf <= 1'b0;
      end
   end

   generate
      if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
         assign data_out = w_rdata;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] r_dout;
         always_ff @(posedge clk) begin
            if (rst)           r_dout <= '0;
            else if (w_rd_acc) r_dout <= w_rdata;
         end
         assign data_out = r_dout;
      end
   endgenerate

   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= CW'(AF_LEVEL));
   assign almost_empty = (r_count <= CW'(AE_LEVEL));
   assign count        = r_count;
   assign overflow     = r_ovf;
   assign underflow    = r_udf;

endmodule
